keypad_hex_entry: RTL and testbench



---
 rtl/keypad_hex_entry.sv | 153 +++++++++++++++
 tb/tb_keypad_hex_entry.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_hex_entry.sv
// keypad_hex_entry: scans a 4x4 hex keypad, debounces presses and assembles 4-digit hex values
module keypad_hex_entry #(
    parameter int SCAN_DIV       = 4096,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row,
    input  logic        clear,
    output logic [3:0]  col,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_held,
    output logic [15:0] entry,
    output logic [2:0]  digit_count,
    output logic [15:0] value,
    output logic        value_strobe
);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB = CW'(DEBOUNCE_SCANS);
    // hex code of the key at index {row,col}; index 0 sits in the low nibble
    localparam logic [63:0] KEYMAP = 64'hDEF0_C987_B654_A321;

    typedef enum logic [1:0] {RELEASED, HELD, REL_WAIT} db_state_t;

    logic [3:0]    row_s1_q, row_s2_q;
    logic [SW-1:0] slot_q;
    logic [1:0]    colsel_q;
    logic [3:0]    col_q;
    logic [15:0]   acc_q, sweep_d;
    db_state_t     st_q;
    logic [CW-1:0] cnt_q, cnt_inc;
    logic [3:0]    cand_q, k, key_code_q;
    logic [4:0]    n;
    logic          key_valid_q, strobe_q;
    logic [15:0]   entry_q, value_q;
    logic [2:0]    digit_q;
    logic          sample, sweep_done, single, none, accept;

    assign sample     = slot_q == SLOT_LAST;
    assign sweep_done = sample && colsel_q == 2'd3;
    assign single     = n == 5'd1;
    assign none       = n == 5'd0;
    assign cnt_inc    = (cnt_q == '0 || k != cand_q) ? CW'(1) : cnt_q + 1'b1;
    assign accept     = sweep_done && st_q == RELEASED && single && cnt_inc == DB;

    assign col          = col_q;
    assign key_valid    = key_valid_q;
    assign key_code     = key_code_q;
    assign key_held     = st_q != RELEASED;
    assign entry        = entry_q;
    assign digit_count  = digit_q;
    assign value        = value_q;
    assign value_strobe = strobe_q;

    // sweep image with the column being sampled right now merged in
    always_comb begin
        sweep_d = acc_q;
        for (int r = 0; r < 4; r++) sweep_d[{r[1:0], colsel_q}] = ~row_s2_q[r];
    end

    // count pressed keys in the sweep and pick the code of one of them
    always_comb begin
        n = '0;
        k = '0;
        for (int i = 15; i >= 0; i--) begin
            if (sweep_d[i]) begin
                n = n + 5'd1;
                k = KEYMAP[{i[3:0], 2'b00} +: 4];
            end
        end
    end

    // synchronize rows, run the slot counter and rotate the active column
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1_q <= 4'hF;
            row_s2_q <= 4'hF;
            slot_q   <= '0;
            colsel_q <= '0;
            col_q    <= 4'b1110;
            acc_q    <= '0;
        end else begin
            row_s1_q <= row;
            row_s2_q <= row_s1_q;
            slot_q   <= sample ? '0 : slot_q + 1'b1;
            if (sample) begin
                colsel_q <= colsel_q + 1'b1;
                col_q    <= {col_q[2:0], col_q[3]};
                acc_q    <= sweep_d;
            end
        end
    end

    // debounce whole-sweep classifications into a single press event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= RELEASED;
            cnt_q       <= '0;
            cand_q      <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
        end else begin
            key_valid_q <= accept;
            if (accept) key_code_q <= k;
            if (sweep_done) begin
                case (st_q)
                    RELEASED: begin
                        if (single) cand_q <= k;
                        cnt_q <= (single && !accept) ? cnt_inc : '0;
                        if (accept) st_q <= HELD;
                    end
                    HELD: begin
                        if (none) begin
                            st_q  <= (DB == CW'(1)) ? RELEASED : REL_WAIT;
                            cnt_q <= (DB == CW'(1)) ? '0 : CW'(1);
                        end
                    end
                    REL_WAIT: begin
                        st_q  <= !none ? HELD : (cnt_q + 1'b1 >= DB) ? RELEASED : REL_WAIT;
                        cnt_q <= (none && cnt_q + 1'b1 < DB) ? cnt_q + 1'b1 : '0;
                    end
                    default: st_q <= RELEASED;
                endcase
            end
        end
    end

    // shift accepted digits in from the right; clear beats a coincident key
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q  <= '0;
            digit_q  <= '0;
            value_q  <= '0;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            if (clear) begin
                entry_q <= '0;
                digit_q <= '0;
            end else if (accept) begin
                entry_q <= (digit_q == 3'd3) ? '0 : {entry_q[11:0], k};
                digit_q <= (digit_q == 3'd3) ? '0 : digit_q + 1'b1;
                if (digit_q == 3'd3) begin
                    value_q  <= {entry_q[11:0], k};
                    strobe_q <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_keypad_hex_entry.sv
// tb_keypad_hex_entry: random and directed keypad activity checked against a sweep-level model
module tb_keypad_hex_entry;
    localparam int S = 8, D = 2, SWEEP = 4 * S;
    localparam int REL = 0, HLD = 1, RW = 2;

    logic clk = 1'b0, rst_n = 1'b1, clear = 1'b0;
    logic [3:0]  row, col, key_code;
    logic        key_valid, key_held, value_strobe;
    logic [15:0] entry, value;
    logic [2:0]  digit_count;
    logic [15:0] keys = '0;
    logic [3:0]  hexat [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA}, '{4'h4, 4'h5, 4'h6, 4'hB},
                                  '{4'h7, 4'h8, 4'h9, 4'hC}, '{4'h0, 4'hF, 4'hE, 4'hD}};
    int n_cmp = 0, n_bad = 0, ev = 0, nstb = 0, coinc = 0;

    int          m_slot = 0, m_col = 0, m_state = REL, m_cnt = 0, m_digits = 0;
    logic [3:0]  m_cand = '0, m_code = '0, cv;
    logic [15:0] m_img = '0, m_prev = '0, h1 = '0, h2 = '0, m_entry = '0, m_value = '0;
    bit          m_valid = 0, m_strobe = 0;

    always #5 clk = ~clk;

    keypad_hex_entry #(.SCAN_DIV(S), .DEBOUNCE_SCANS(D)) dut (
        .clk(clk), .rst_n(rst_n), .row(row), .clear(clear), .col(col),
        .key_valid(key_valid), .key_code(key_code), .key_held(key_held),
        .entry(entry), .digit_count(digit_count), .value(value), .value_strobe(value_strobe)
    );

    // keypad: a row reads low while its column is driven low and that key is down
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!col[c] && keys[hexat[r][c]]) row[r] = 1'b0;
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_slot = 0; m_col = 0; m_state = REL; m_cnt = 0; m_digits = 0;
        m_cand = '0; m_code = '0; m_img = '0; m_prev = '0; h1 = '0; h2 = '0;
        m_entry = '0; m_value = '0; m_valid = 0; m_strobe = 0;
    endtask

    task automatic model_step();
        logic [15:0] samp;
        logic [3:0]  code;
        int          n;
        bit          acc;
        samp = h2; h2 = h1; h1 = keys;
        m_valid = 0; m_strobe = 0; acc = 0;
        if (m_slot == S - 1) begin
            for (int r = 0; r < 4; r++) m_img[hexat[r][m_col]] = samp[hexat[r][m_col]];
            if (m_col == 3) begin
                n = $countones(m_img);
                code = '0;
                for (int h = 0; h < 16; h++) if (m_img[h]) code = h[3:0];
                case (m_state)
                    REL: begin
                        if (n == 1) begin
                            m_cnt  = (code != m_cand || m_prev != m_img) ? 1 : m_cnt + 1;
                            m_cand = code;
                            if (m_cnt == D) begin
                                m_state = HLD; m_code = code; m_valid = 1; acc = 1; m_cnt = 0;
                            end
                        end else m_cnt = 0;
                    end
                    HLD: begin
                        if (n == 0) begin
                            m_state = RW; m_cnt = 1;
                            if (m_cnt >= D) begin m_state = REL; m_cnt = 0; end
                        end
                    end
                    default: begin
                        if (n != 0) m_state = HLD;
                        else begin
                            m_cnt++;
                            if (m_cnt >= D) begin m_state = REL; m_cnt = 0; end
                        end
                    end
                endcase
                m_prev = m_img;
            end
            m_col = (m_col + 1) % 4;
            m_slot = 0;
        end else m_slot++;
        if (clear) begin
            m_entry = '0; m_digits = 0;
        end else if (acc) begin
            if (m_digits == 3) begin
                m_value = {m_entry[11:0], m_code}; m_entry = '0; m_digits = 0; m_strobe = 1;
            end else begin
                m_entry = {m_entry[11:0], m_code}; m_digits++;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else model_step();
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            cv = 4'b0001 << m_col;
            cv = ~cv;
            chk("col", 16'(col), 16'(cv));
            chk("key_valid", 16'(key_valid), 16'(m_valid));
            chk("key_code", 16'(key_code), 16'(m_code));
            chk("key_held", 16'(key_held), 16'(m_state != REL));
            chk("entry", entry, m_entry);
            chk("digit_count", 16'(digit_count), 16'(m_digits));
            chk("value", value, m_value);
            chk("value_strobe", 16'(value_strobe), 16'(m_strobe));
            if (key_valid) ev++;
            if (value_strobe) nstb++;
            if (value_strobe && key_valid) coinc++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tap(input logic [15:0] m, input int on_sw, input int off_sw);
        keys = m;
        cyc(on_sw * SWEEP);
        keys = '0;
        cyc(off_sw * SWEEP);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_col"}, 16'(col), 16'h000E);
        chk({tag, "_valid"}, 16'(key_valid), 16'h0);
        chk({tag, "_code"}, 16'(key_code), 16'h0);
        chk({tag, "_held"}, 16'(key_held), 16'h0);
        chk({tag, "_entry"}, entry, 16'h0);
        chk({tag, "_digits"}, 16'(digit_count), 16'h0);
        chk({tag, "_value"}, value, 16'h0);
        chk({tag, "_strobe"}, 16'(value_strobe), 16'h0);
    endtask

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0]  dg [4] = '{4'h1, 4'hA, 4'h0, 4'hF};
        logic [15:0] steps [3] = '{16'h0001, 16'h001A, 16'h01A0};
        int e0, s0;
        #1 rst_n = 1'b0;
        #1 chk_all_zero("reset");
        cyc(3);
        rst_n = 1'b1;
        cyc(8 * SWEEP);
        chk("idle_events", 16'(ev), 16'd0);

        tap(16'h0020, 10, 0);
        chk("k5_events", 16'(ev), 16'd1);
        chk("k5_code", 16'(key_code), 16'h5);
        chk("k5_entry", entry, 16'h0005);
        chk("k5_digits", 16'(digit_count), 16'd1);
        chk("k5_held", 16'(key_held), 16'd1);
        cyc(SWEEP);
        chk("k5_held_1sweep", 16'(key_held), 16'd1);
        cyc(2 * SWEEP + 2);
        chk("k5_released", 16'(key_held), 16'd0);

        clear = 1'b1; cyc(1); clear = 1'b0;
        chk("clear_entry", entry, 16'h0);
        chk("clear_digits", 16'(digit_count), 16'd0);
        s0 = nstb;
        for (int i = 0; i < 4; i++) begin
            tap(16'(1) << dg[i], 4, 4);
            if (i < 3) chk("digit_entry", entry, steps[i]);
        end
        chk("value_1A0F", value, 16'h1A0F);
        chk("model_value", m_value, 16'h1A0F);
        chk("value_entry0", entry, 16'h0);
        chk("value_digits0", 16'(digit_count), 16'd0);
        chk("strobe_count", 16'(nstb - s0), 16'd1);
        chk("strobe_with_valid", 16'(coinc), 16'd1);

        e0 = ev;
        repeat (4) begin
            keys = 16'h0008; cyc(SWEEP);
            keys = '0;       cyc(SWEEP);
        end
        chk("bounce_none", 16'(ev), 16'(e0));
        tap(16'h0008, 4, 4);
        chk("bounce_one", 16'(ev), 16'(e0 + 1));
        chk("bounce_code", 16'(key_code), 16'h3);

        e0 = ev;
        tap(16'h0104, 6, 4);
        chk("multi_none", 16'(ev), 16'(e0));
        keys = 16'h0080; cyc(4 * SWEEP);
        keys = 16'h0280; cyc(4 * SWEEP);
        keys = '0;       cyc(4 * SWEEP);
        chk("hold7_one", 16'(ev - e0), 16'd1);
        chk("hold7_code", 16'(key_code), 16'h7);

        clear = 1'b1; cyc(1); clear = 1'b0;
        tap(16'h0002, 4, 4);
        tap(16'h0004, 4, 4);
        chk("two_digits", entry, 16'h0012);
        e0 = ev; s0 = nstb;
        clear = 1'b1;
        tap(16'h0040, 4, 4);
        clear = 1'b0;
        chk("clr3_event", 16'(ev - e0), 16'd1);
        chk("clr3_entry", entry, 16'h0);
        chk("clr3_digits", 16'(digit_count), 16'd0);
        tap(16'h0010, 4, 4);
        tap(16'h0020, 4, 4);
        tap(16'h0040, 4, 4);
        chk("three_digits", entry, 16'h0456);
        clear = 1'b1;
        tap(16'h2000, 4, 4);
        clear = 1'b0;
        chk("clr4_nostrobe", 16'(nstb - s0), 16'd0);
        chk("clr4_value", value, 16'h1A0F);
        chk("clr4_entry", entry, 16'h0);

        tap(16'h0200, 4, 2);
        cyc(13);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("midreset");
        e0 = ev;
        cyc(2);
        rst_n = 1'b1;
        cyc(2 * SWEEP);
        chk("after_reset_events", 16'(ev), 16'(e0));

        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(5))
                0, 1: tap(16'(1) << $urandom_range(15), $urandom_range(1, 5), $urandom_range(0, 4));
                2: begin
                    keys = 16'($urandom) & 16'($urandom);
                    cyc($urandom_range(8, 80));
                end
                3: begin
                    repeat ($urandom_range(2, 8)) begin
                        keys = $urandom_range(1) ? 16'(1) << $urandom_range(15) : 16'h0;
                        cyc($urandom_range(3, 40));
                    end
                end
                4: begin
                    clear = 1'b1; cyc($urandom_range(1, 3)); clear = 1'b0;
                end
                default: begin
                    keys = '0;
                    cyc($urandom_range(1, 100));
                end
            endcase
        end
        keys = '0;
        cyc(4 * SWEEP);
        chk("final_released", 16'(key_held), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
